// File: rtl/getbits_pkg.sv
// Shared constants and helpers for the bitstream getbits window.
package getbits_pkg;

  localparam int GB_IN_WIDTH  = 32;
  localparam int GB_WIN_WIDTH = 24;
  localparam int GB_BUF_WIDTH = 64;

  function automatic logic [4:0] sat_adv(
    input logic [4:0] adv
  );
    if (adv > 5'(GB_WIN_WIDTH)) begin
      return 5'(GB_WIN_WIDTH);
    end
    return adv;
  endfunction

endpackage

// File: rtl/getbits_merge.sv
// Shifts the buffer left by the consumed bit count and
// ORs a newly popped word in just below the remaining bits.
module getbits_merge
  import getbits_pkg::*;
#(
  parameter int IN_WIDTH  = GB_IN_WIDTH,
  parameter int BUF_WIDTH = GB_BUF_WIDTH,
  parameter int CNT_WIDTH = 7
) (
  input  logic [BUF_WIDTH-1:0] buf_i,
  input  logic [CNT_WIDTH-1:0] c,
  input  logic [CNT_WIDTH-1:0] rem,
  input  logic [IN_WIDTH-1:0]  word,
  input  logic                 ins,
  output logic [BUF_WIDTH-1:0] buf_o
);

  logic [BUF_WIDTH-1:0] word_ext;

  always_comb begin
    // Left-justify the word, then slide it under the rem kept bits.
    word_ext = {word, {IN_WIDTH{1'b0}}} >> rem;
    buf_o    = buf_i << c;
    if (ins) begin
      buf_o = buf_o | word_ext;
    end
  end

endmodule

// File: rtl/getbits_window.sv
// MSB-first lookahead window over a 32-bit FWFT word stream.
// Define GETBITS_STATS_EN to add the bits_consumed counter.
module getbits_window
  import getbits_pkg::*;
#(
  parameter int IN_WIDTH  = GB_IN_WIDTH,
  parameter int WIN_WIDTH = GB_WIN_WIDTH,
  parameter int ADV_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 fwft_valid,
  input  logic [IN_WIDTH-1:0]  fwft_dout,
  output logic                 fwft_rd_en,
  output logic [WIN_WIDTH-1:0] getbits,
  output logic                 getbits_valid,
  input  logic [ADV_WIDTH-1:0] advance,
  input  logic                 align,
  input  logic                 flush
`ifdef GETBITS_STATS_EN
  ,
  output logic [31:0]          bits_consumed
`endif
);

  localparam int BUF_WIDTH = 2 * IN_WIDTH;
  localparam int CNT_WIDTH = $clog2(BUF_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] IN_CNT =
    CNT_WIDTH'(IN_WIDTH);
  localparam logic [CNT_WIDTH-1:0] WIN_CNT =
    CNT_WIDTH'(WIN_WIDTH);

  logic [BUF_WIDTH-1:0] buf_q, buf_d, buf_m;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] c, rem;
  logic                 take;

  assign take = clk_en & fwft_valid & ~flush &
                (cnt_q <= IN_CNT);
  assign fwft_rd_en    = take;
  assign getbits       = buf_q[BUF_WIDTH-1 -: WIN_WIDTH];
  assign getbits_valid = (cnt_q >= WIN_CNT);

  always_comb begin
    c = '0;
    if (getbits_valid) begin
      if (align) begin
        c = CNT_WIDTH'(cnt_q[2:0]);
      end else begin
        c = CNT_WIDTH'(sat_adv(advance));
      end
    end
    rem = cnt_q - c;
  end

  getbits_merge #(
    .IN_WIDTH  (IN_WIDTH),
    .BUF_WIDTH (BUF_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_merge (
    .buf_i (buf_q),
    .c     (c),
    .rem   (rem),
    .word  (fwft_dout),
    .ins   (take),
    .buf_o (buf_m)
  );

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clk_en) begin
      if (flush) begin
        buf_d = '0;
        cnt_d = '0;
      end else begin
        buf_d = buf_m;
        cnt_d = rem + (take ? IN_CNT : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef GETBITS_STATS_EN
  logic [31:0] stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (clk_en) begin
      if (flush) begin
        stats_d = '0;
      end else begin
        stats_d = stats_q + 32'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign bits_consumed = stats_q;
`endif

endmodule

// File: tb/tb_getbits_window.sv
// Directed vector bench for getbits_window with a small
// FWFT source model feeding a fixed word list.
module tb_getbits_window;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        fwft_valid;
  logic [31:0] fwft_dout;
  logic        fwft_rd_en;
  logic [23:0] getbits;
  logic        getbits_valid;
  logic [4:0]  advance;
  logic        align;
  logic        flush;
  logic        src_en;
`ifdef GETBITS_STATS_EN
  logic [31:0] bits_consumed;
`endif

  logic [31:0] words [16];
  logic [4:0]  idx;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  getbits_window dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .fwft_valid    (fwft_valid),
    .fwft_dout     (fwft_dout),
    .fwft_rd_en    (fwft_rd_en),
    .getbits       (getbits),
    .getbits_valid (getbits_valid),
    .advance       (advance),
    .align         (align),
    .flush         (flush)
`ifdef GETBITS_STATS_EN
    ,
    .bits_consumed (bits_consumed)
`endif
  );

  assign fwft_valid = src_en && (idx < 5'd16);
  assign fwft_dout  = words[idx[3:0]];

  always @(posedge clk) begin
    if (!rst) idx <= '0;
    else if (fwft_rd_en) idx <= idx + 5'd1;
  end

  typedef struct {
    logic [4:0]  adv;
    logic        al;
    logic        src;
    logic        rd;
    logic [23:0] gb;
    logic        v;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  name, act, exp);
  endtask

  task automatic step(input string name,
                      input logic ce,
                      input logic [4:0] adv,
                      input logic al,
                      input logic fl,
                      input logic src,
                      input logic rd,
                      input logic [23:0] gb,
                      input logic v);
    @(negedge clk);
    clk_en  = ce;
    advance = adv;
    align   = al;
    flush   = fl;
    src_en  = src;
    #1;
    chk({name, ".rd_en"}, 32'(fwft_rd_en), 32'(rd));
    @(posedge clk);
    #1;
    chk({name, ".getbits"}, 32'(getbits), 32'(gb));
    chk({name, ".valid"}, 32'(getbits_valid), 32'(v));
  endtask

  initial begin
    words[0] = 32'h12345678;
    words[1] = 32'h9ABCDEF0;
    words[2] = 32'h0FEDCBA9;
    words[3] = 32'h87654321;
    words[4] = 32'hDEADBEEF;
    words[5] = 32'hCAFEF00D;
    words[6] = 32'h01234567;
    words[7] = 32'h89ABCDEF;
    words[8] = 32'h5A5AC3C3;
    words[9] = 32'hF0E1D2C3;
    for (int i = 10; i < 16; i++) words[i] = '0;

    //            adv   al    src   rd    gb           v
    tbl[0]  = '{5'd0,  1'b0, 1'b1, 1'b1, 24'h123456, 1'b1};
    tbl[1]  = '{5'd0,  1'b0, 1'b1, 1'b1, 24'h123456, 1'b1};
    tbl[2]  = '{5'd0,  1'b0, 1'b1, 1'b0, 24'h123456, 1'b1};
    tbl[3]  = '{5'd3,  1'b0, 1'b1, 1'b0, 24'h91A2B3, 1'b1};
    tbl[4]  = '{5'd0,  1'b1, 1'b1, 1'b0, 24'h345678, 1'b1};
    tbl[5]  = '{5'd0,  1'b1, 1'b1, 1'b0, 24'h345678, 1'b1};
    tbl[6]  = '{5'd31, 1'b0, 1'b1, 1'b0, 24'h9ABCDE, 1'b1};
    tbl[7]  = '{5'd4,  1'b0, 1'b1, 1'b1, 24'hABCDEF, 1'b1};
    tbl[8]  = '{5'd4,  1'b0, 1'b1, 1'b0, 24'hBCDEF0, 1'b1};
    tbl[9]  = '{5'd4,  1'b0, 1'b1, 1'b0, 24'hCDEF00, 1'b1};
    tbl[10] = '{5'd4,  1'b0, 1'b1, 1'b0, 24'hDEF00F, 1'b1};
    tbl[11] = '{5'd24, 1'b0, 1'b1, 1'b0, 24'hEDCBA9, 1'b1};
    tbl[12] = '{5'd24, 1'b0, 1'b1, 1'b1, 24'h876543, 1'b1};
    tbl[13] = '{5'd24, 1'b0, 1'b1, 1'b1, 24'h21DEAD, 1'b1};
    tbl[14] = '{5'd24, 1'b0, 1'b1, 1'b0, 24'hBEEF00, 1'b0};
    tbl[15] = '{5'd5,  1'b0, 1'b1, 1'b1, 24'hBEEFCA, 1'b1};
    tbl[16] = '{5'd0,  1'b1, 1'b1, 1'b0, 24'hBEEFCA, 1'b1};
    tbl[17] = '{5'd12, 1'b0, 1'b1, 1'b0, 24'hFCAFEF, 1'b1};
    tbl[18] = '{5'd1,  1'b0, 1'b1, 1'b0, 24'hF95FDE, 1'b1};
    tbl[19] = '{5'd0,  1'b1, 1'b1, 1'b0, 24'hCAFEF0, 1'b1};
    tbl[20] = '{5'd0,  1'b0, 1'b1, 1'b1, 24'hCAFEF0, 1'b1};
    tbl[21] = '{5'd24, 1'b0, 1'b0, 1'b0, 24'h0D0123, 1'b1};
    tbl[22] = '{5'd24, 1'b0, 1'b0, 1'b0, 24'h456700, 1'b0};
    tbl[23] = '{5'd24, 1'b0, 1'b0, 1'b0, 24'h456700, 1'b0};
    tbl[24] = '{5'd0,  1'b0, 1'b1, 1'b1, 24'h456789, 1'b1};

    rst     = 1'b0;
    clk_en  = 1'b1;
    advance = '0;
    align   = 1'b0;
    flush   = 1'b0;
    src_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.getbits", 32'(getbits), 32'h0);
    chk("reset.valid", 32'(getbits_valid), 32'h0);
    chk("reset.rd_en", 32'(fwft_rd_en), 32'h0);
`ifdef GETBITS_STATS_EN
    chk("reset.stats", bits_consumed, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step($sformatf("vec%0d", i), 1'b1,
           tbl[i].adv, tbl[i].al, 1'b0, tbl[i].src,
           tbl[i].rd, tbl[i].gb, tbl[i].v);
    end

    // flush with a word on offer, then refill
    step("flush", 1'b1, 5'd4, 1'b0, 1'b1, 1'b1,
         1'b0, 24'h000000, 1'b0);
`ifdef GETBITS_STATS_EN
    chk("flush.stats", bits_consumed, 32'h0);
`endif
    step("refill0", 1'b1, 5'd0, 1'b0, 1'b0, 1'b1,
         1'b1, 24'h5A5AC3, 1'b1);
    step("refill1", 1'b1, 5'd8, 1'b0, 1'b0, 1'b1,
         1'b1, 24'h5AC3C3, 1'b1);
`ifdef GETBITS_STATS_EN
    chk("adv8.stats", bits_consumed, 32'd8);
`endif
    step("clk_en0", 1'b0, 5'd8, 1'b0, 1'b0, 1'b1,
         1'b0, 24'h5AC3C3, 1'b1);

    // reset mid-stream
    @(negedge clk);
    clk_en  = 1'b1;
    rst     = 1'b0;
    src_en  = 1'b0;
    advance = '0;
    #1;
    chk("rst2.rd_en", 32'(fwft_rd_en), 32'h0);
    @(posedge clk);
    #1;
    chk("rst2.getbits", 32'(getbits), 32'h0);
    chk("rst2.valid", 32'(getbits_valid), 32'h0);
`ifdef GETBITS_STATS_EN
    chk("rst2.stats", bits_consumed, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // saturation of advance from a full buffer
    step("sat0", 1'b1, 5'd0, 1'b0, 1'b0, 1'b1,
         1'b1, 24'h123456, 1'b1);
    step("sat1", 1'b1, 5'd0, 1'b0, 1'b0, 1'b1,
         1'b1, 24'h123456, 1'b1);
    step("sat31", 1'b1, 5'd31, 1'b0, 1'b0, 1'b1,
         1'b0, 24'h789ABC, 1'b1);
    step("sat16", 1'b1, 5'd16, 1'b0, 1'b0, 1'b1,
         1'b0, 24'hBCDEF0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
